shared_mem: RTL and testbench

SHARED_MEM -- requirements
Module: shared_mem

---
 rtl/shared_mem.sv | 140 ++++++++++++++
 tb/tb_shared_mem.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shared_mem.sv
// rtl/shared_mem.sv - multi-port shared word memory with round-robin arbitration and wait states
module shared_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int N_PORTS     = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [N_PORTS-1:0]            en,
  input  logic [N_PORTS-1:0]            rw,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] address,
  input  logic [N_PORTS*DATA_WIDTH-1:0] data_in,
  output logic [N_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [N_PORTS-1:0]            miss
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                        state_q;
  logic [3:0]                    cnt_q;
  logic [PW-1:0]                 last_q;
  logic [PW-1:0]                 grant_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic                          rw_q;
  logic [DATA_WIDTH-1:0]         wdata_q;
  logic [N_PORTS*DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0]         mem [DEPTH];

  logic                          arb_valid;
  logic [PW-1:0]                 arb_port;
  logic [PW-1:0]                 cand;
  logic                          do_acc;
  logic [PW-1:0]                 acc_port;
  logic [ADDR_WIDTH-1:0]         acc_addr;
  logic                          acc_rw;
  logic [DATA_WIDTH-1:0]         acc_wdata;
  logic                          in_range;
  logic [IDXW-1:0]               acc_idx;
  logic                          mem_we;
  logic                          unused_addr_bits;

  // Round-robin: first requester strictly after the last-granted port
  always_comb begin
    arb_valid = 1'b0;
    arb_port  = last_q;
    cand      = last_q;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = PW'((int'(last_q) + k) % N_PORTS);
      if (!arb_valid && en[cand]) begin
        arb_valid = 1'b1;
        arb_port  = cand;
      end
    end
  end

  // Select the access performed on this edge: live inputs when there are no wait states, latched otherwise
  always_comb begin
    do_acc    = 1'b0;
    acc_port  = grant_q;
    acc_addr  = addr_q;
    acc_rw    = rw_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE && arb_valid && WAIT_STATES == 0) begin
      do_acc    = 1'b1;
      acc_port  = arb_port;
      acc_addr  = address[arb_port*ADDR_WIDTH +: ADDR_WIDTH];
      acc_rw    = rw[arb_port];
      acc_wdata = data_in[arb_port*DATA_WIDTH +: DATA_WIDTH];
    end else if (state_q == WAIT && en[grant_q] && cnt_q == 4'd1) begin
      do_acc = 1'b1;
    end
  end

  assign in_range         = ((acc_addr >> (IDXW + 2)) == '0);
  assign acc_idx          = acc_addr[IDXW+1:2];
  assign mem_we           = do_acc & acc_rw & in_range & Rst;
  assign unused_addr_bits = ^acc_addr[1:0];
  assign data_out         = dout_q;

  // Stall every requesting port except the one completing this cycle
  always_comb begin
    miss = en;
    for (int i = 0; i < N_PORTS; i++) begin
      if (state_q == DONE && grant_q == PW'(i)) miss[i] = 1'b0;
    end
  end

  // Access FSM: grant and latch in IDLE, count down in WAIT, one-cycle DONE
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= PW'(N_PORTS - 1);
      grant_q <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_port;
            last_q  <= arb_port;
            addr_q  <= address[arb_port*ADDR_WIDTH +: ADDR_WIDTH];
            rw_q    <= rw[arb_port];
            wdata_q <= data_in[arb_port*DATA_WIDTH +: DATA_WIDTH];
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!en[grant_q]) begin
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (do_acc && !acc_rw) begin
        dout_q[acc_port*DATA_WIDTH +: DATA_WIDTH] <= in_range ? mem[acc_idx] : '0;
      end
    end
  end

  // Memory array is never reset; writes land on the DONE-entry edge
  always_ff @(posedge Clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_shared_mem.sv
// tb/tb_shared_mem.sv - directed self-checking bench for shared_mem
module tb_shared_mem;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;

  logic [1:0]  a_en, a_rw, a_miss;
  logic [63:0] a_addr, a_din, a_dout;
  logic [1:0]  b_en, b_rw, b_miss;
  logic [63:0] b_addr, b_din, b_dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] arb_exp [12];

  always #5 Clk = ~Clk;

  shared_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .N_PORTS(2), .WAIT_STATES(1)) dut_a (
    .Clk(Clk), .Rst(Rst), .en(a_en), .rw(a_rw), .address(a_addr),
    .data_in(a_din), .data_out(a_dout), .miss(a_miss)
  );

  shared_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .N_PORTS(2), .WAIT_STATES(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .en(b_en), .rw(b_rw), .address(b_addr),
    .data_in(b_din), .data_out(b_dout), .miss(b_miss)
  );

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access on dut_a starting from IDLE; checks the miss profile high, high, low
  task automatic acc_a(input string tag, input int p, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    logic [1:0] m;
    m    = '0;
    m[p] = 1'b1;
    a_en      = m;
    a_rw[p]   = w;
    a_addr[p*32 +: 32] = a;
    a_din[p*32 +: 32]  = d;
    #1 chk({tag, "_miss_idle"}, a_miss, m);
    cyc();
    chk({tag, "_miss_wait"}, a_miss, m);
    cyc();
    chk({tag, "_miss_done"}, a_miss, 2'b00);
    a_en = '0;
    cyc();
  endtask

  initial begin
    arb_exp = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01,
                2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01};
    a_en = '0; a_rw = '0; a_addr = '0; a_din = '0;
    b_en = '0; b_rw = '0; b_addr = '0; b_din = '0;

    // Reset state
    repeat (2) cyc();
    chk("rst_dout", a_dout, 64'h0);
    a_en = 2'b11;
    #1 chk("rst_miss_eq_en", a_miss, 2'b11);
    a_en = 2'b00;
    #1 chk("rst_miss_idle", a_miss, 2'b00);
    Rst = 1'b1;
    cyc();

    // Write then read with one wait state
    acc_a("w10", 0, 1'b1, 32'h10, 32'hDEADBEEF);
    acc_a("r10", 0, 1'b0, 32'h10, 32'h0);
    chk("r10_data", a_dout[31:0], 32'hDEADBEEF);
    acc_a("w20", 0, 1'b1, 32'h20, 32'hA5A5A5A5);
    acc_a("w00_p1", 1, 1'b1, 32'h0, 32'h00000077);
    chk("write_keeps_dout", a_dout[31:0], 32'hDEADBEEF);

    // Address/data/rw changes during WAIT are ignored
    a_en = 2'b01; a_rw = 2'b01; a_addr[31:0] = 32'h30; a_din[31:0] = 32'h0BADF00D;
    #1;
    cyc();
    a_addr[31:0] = 32'h34; a_din[31:0] = 32'h0; a_rw = 2'b00;
    cyc();
    chk("latch_miss_done", a_miss, 2'b00);
    a_en = 2'b00;
    cyc();
    acc_a("r30", 0, 1'b0, 32'h30, 32'h0);
    chk("r30_latched_data", a_dout[31:0], 32'h0BADF00D);

    // Abort: en dropped during WAIT
    a_en = 2'b01; a_rw = 2'b01; a_addr[31:0] = 32'h20; a_din[31:0] = 32'h11111111;
    #1;
    cyc();
    a_en = 2'b00;
    #1 chk("abort_miss", a_miss, 2'b00);
    cyc();
    acc_a("r20", 0, 1'b0, 32'h20, 32'h0);
    chk("abort_mem_unchanged", a_dout[31:0], 32'hA5A5A5A5);

    // Out of range
    acc_a("w1000", 0, 1'b1, 32'h1000, 32'h5);
    acc_a("r1000", 0, 1'b0, 32'h1000, 32'h0);
    chk("oor_read_zero", a_dout[31:0], 32'h0);
    acc_a("r00", 0, 1'b0, 32'h0, 32'h0);
    chk("oor_mem0_unchanged", a_dout[31:0], 32'h00000077);

    // Reset during WAIT of a write
    a_en = 2'b01; a_rw = 2'b01; a_addr[31:0] = 32'h10; a_din[31:0] = 32'h12345678;
    #1;
    cyc();
    Rst = 1'b0;
    #1 chk("midrst_dout", a_dout, 64'h0);
    chk("midrst_miss_idle", a_miss, 2'b01);
    a_en = 2'b00;
    cyc();
    Rst = 1'b1;
    cyc();
    acc_a("r10b", 0, 1'b0, 32'h10, 32'h0);
    chk("midrst_mem_unchanged", a_dout[31:0], 32'hDEADBEEF);

    // Round-robin after a fresh reset: port 0 first, then alternating
    Rst = 1'b0;
    cyc();
    Rst = 1'b1;
    a_en = 2'b11; a_rw = 2'b00; a_addr = {32'h20, 32'h10};
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("arb_miss_c%0d", i), a_miss, arb_exp[i]);
      if (i == 2) chk("arb_p0_data", a_dout[31:0], 32'hDEADBEEF);
      if (i == 5) chk("arb_p1_data", a_dout[63:32], 32'hA5A5A5A5);
      cyc();
    end
    a_en = 2'b00;
    cyc();

    // Zero wait states on dut_b, port 1
    b_en = 2'b10; b_rw = 2'b10; b_addr[63:32] = 32'h0; b_din[63:32] = 32'h5A5A0001;
    #1 chk("zw_w_miss_idle", b_miss, 2'b10);
    cyc();
    chk("zw_w_miss_done", b_miss, 2'b00);
    b_en = 2'b00;
    cyc();
    b_en = 2'b10; b_rw = 2'b00;
    #1 chk("zw_r_miss_idle", b_miss, 2'b10);
    cyc();
    chk("zw_r_miss_done", b_miss, 2'b00);
    chk("zw_r_data", b_dout[63:32], 32'h5A5A0001);
    b_en = 2'b00;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
